// File: rtl/avalon_mm_csr_pkg.sv
// Shared widths, FSM state type and default ID word for the Avalon-MM CSR responder.
package avalon_mm_csr_pkg;

   localparam int unsigned AVMM_ADDR_W = 17;
   localparam int unsigned AVMM_DATA_W = 32;
   localparam int unsigned AVMM_BE_W   = 4;

   localparam logic [AVMM_DATA_W-1:0] CSR_ID_DEFAULT = 32'hA1B0_0001;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCEPT,
      RDLAT
   } csr_rsp_state_e;

endpackage

// File: rtl/avalon_mm_csr_be_merge.sv
// Byte-lane merge: each enabled lane takes new_data, the others keep old_data.
module avalon_mm_csr_be_merge
   import avalon_mm_csr_pkg::*;
(
   input  logic [AVMM_DATA_W-1:0] old_data,
   input  logic [AVMM_DATA_W-1:0] new_data,
   input  logic [AVMM_BE_W-1:0]   byteenable,
   output logic [AVMM_DATA_W-1:0] merged
);

   always_comb begin
      merged = old_data;
      for (int b = 0; b < AVMM_BE_W; b++) begin
         if (byteenable[b]) merged[8*b +: 8] = new_data[8*b +: 8];
      end
   end

endmodule

// File: rtl/avalon_mm_csr_responder.sv
// Avalon-MM CSR responder: byte-enabled register bank, programmable wait states, fixed read latency.
// Define AVMM_CSR_RSP_ID_REG_EN to make register 0 a read-only ID word.
module avalon_mm_csr_responder
   import avalon_mm_csr_pkg::*;
#(
   parameter int unsigned                NUM_REGS     = 16,
   parameter logic [AVMM_ADDR_W-1:0]     BASE_ADDR    = 17'h0,
   parameter int unsigned                WAIT_STATES  = 1,
   parameter int unsigned                READ_LATENCY = 2,
   parameter logic [AVMM_DATA_W-1:0]     ID_VALUE     = CSR_ID_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [AVMM_ADDR_W-1:0]          address,
   input  logic                            read,
   input  logic                            write,
   input  logic [AVMM_DATA_W-1:0]          writedata,
   input  logic [AVMM_BE_W-1:0]            byteenable,
   output logic [AVMM_DATA_W-1:0]          readdata,
   output logic                            readdatavalid,
   output logic                            waitrequest,
   output logic [AVMM_DATA_W*NUM_REGS-1:0] reg_q,
   output logic [NUM_REGS-1:0]             wr_strobe,
   output logic                            err_addr,
   input  logic                            err_clr
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AVMM_CSR_RSP_ID_REG_EN
   localparam bit RO_REG0 = 1'b1;
`else
   localparam bit RO_REG0 = 1'b0;
   logic unused_id;
   assign unused_id = ^ID_VALUE;
`endif

   csr_rsp_state_e state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [AVMM_DATA_W-1:0] hold_q, rdata_q;
   logic [NUM_REGS-1:0]    wr_strobe_q;
   logic                   err_q;

   // Address decode; the borrow of the subtraction flags addresses below BASE_ADDR.
   logic                   below_base;
   logic [AVMM_ADDR_W-1:0] offset;
   logic [AVMM_ADDR_W-3:0] word_idx;
   logic                   in_range;
   logic [IDX_W-1:0]       sel;
   logic                   unused_addr;

   assign {below_base, offset} = {1'b0, address} - {1'b0, BASE_ADDR};
   assign word_idx    = offset[AVMM_ADDR_W-1:2];
   assign in_range    = !below_base && (32'(word_idx) < NUM_REGS);
   assign sel         = in_range ? word_idx[IDX_W-1:0] : '0;
   assign unused_addr = ^offset[1:0];

   logic acc, id_hit, wr_hit, rd_fire, err_set;

   assign acc     = (state_q == ACCEPT);
   assign id_hit  = RO_REG0 && in_range && (sel == '0);
   assign wr_hit  = acc && write && in_range && !id_hit;
   assign rd_fire = acc && read && !write;
   assign err_set = acc && (read || write) &&
                    (!in_range || (read && write) || (write && id_hit));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (read || write) begin
               if (WAIT_STATES == 0) begin
                  state_d = ACCEPT;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = ACCEPT;
            else             cnt_d   = cnt_q - 4'd1;
         end
         ACCEPT: begin
            if (write) begin
               state_d = IDLE;
            end else if (read) begin
               state_d = RDLAT;
               cnt_d   = 4'(READ_LATENCY - 1);
            end else begin
               state_d = IDLE;
            end
         end
         RDLAT: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign waitrequest   = rst || !acc;
   assign readdatavalid = !rst && (state_q == RDLAT) && (cnt_q == '0);
   assign readdata      = readdatavalid ? hold_q : rdata_q;
   assign wr_strobe     = wr_strobe_q;
   assign err_addr      = err_q;

   logic [AVMM_DATA_W-1:0] regs [NUM_REGS];
   logic [AVMM_DATA_W-1:0] merged;

   avalon_mm_csr_be_merge u_be_merge (
      .old_data   (regs[sel]),
      .new_data   (writedata),
      .byteenable (byteenable),
      .merged     (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         rdata_q     <= '0;
         wr_strobe_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_strobe_q <= '0;
         if (wr_hit)        wr_strobe_q[sel] <= 1'b1;
         if (rd_fire)       hold_q  <= in_range ? regs[sel] : '0;
         if (readdatavalid) rdata_q <= hold_q;
         if (err_set)       err_q   <= 1'b1;
         else if (err_clr)  err_q   <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_REG0 && (i == 0)) begin : g_id
         assign regs[i] = ID_VALUE;
      end else begin : g_rw
         logic [AVMM_DATA_W-1:0] word_q;
         always_ff @(posedge clk) begin
            if (rst)                                word_q <= '0;
            else if (wr_hit && (sel == IDX_W'(i))) word_q <= merged;
         end
         assign regs[i] = word_q;
      end
      assign reg_q[AVMM_DATA_W*i +: AVMM_DATA_W] = regs[i];
   end

endmodule

// File: tb/tb_avalon_mm_csr_responder.sv
// Directed bench for avalon_mm_csr_responder; read responses are checked by a queue-driven monitor.
module tb_avalon_mm_csr_responder;

   localparam int unsigned NUM_REGS     = 16;
   localparam int unsigned WAIT_STATES  = 1;
   localparam int unsigned READ_LATENCY = 2;
`ifdef AVMM_CSR_RSP_ID_REG_EN
   localparam logic [31:0] REG0_RST = 32'hA1B0_0001;
`else
   localparam logic [31:0] REG0_RST = 32'h0;
`endif

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [16:0]              address = '0;
   logic                     read = 1'b0;
   logic                     write = 1'b0;
   logic [31:0]              writedata = '0;
   logic [3:0]               byteenable = '0;
   logic [31:0]              readdata;
   logic                     readdatavalid;
   logic                     waitrequest;
   logic [32*NUM_REGS-1:0]   reg_q;
   logic [NUM_REGS-1:0]      wr_strobe;
   logic                     err_addr;
   logic                     err_clr = 1'b0;

   avalon_mm_csr_responder #(
      .NUM_REGS     (NUM_REGS),
      .BASE_ADDR    (17'h0),
      .WAIT_STATES  (WAIT_STATES),
      .READ_LATENCY (READ_LATENCY),
      .ID_VALUE     (32'hA1B0_0001)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .reg_q         (reg_q),
      .wr_strobe     (wr_strobe),
      .err_addr      (err_addr),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   int      errors = 0;
   int      checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int i);
      return reg_q[32*i +: 32];
   endfunction

   // Every readdatavalid pulse must match the oldest expected response, data and cycle.
   always @(negedge clk) begin
      rd_exp_t e;
      if (readdatavalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got readdatavalid data %h, expected no response", readdata);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", readdata, e.data);
            check("rd_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic avm_req(input logic [16:0] a, input logic do_rd, input logic do_wr,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] rd_exp, input bit push, output int waits);
      bit done = 1'b0;
      @(posedge clk);
      #1;
      address    = a;
      read       = do_rd;
      write      = do_wr;
      writedata  = d;
      byteenable = be;
      waits      = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!waitrequest) begin
            done = 1'b1;
            if (push) exp_q.push_back('{rd_exp, cyc + READ_LATENCY});
         end else begin
            waits++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: waitrequest high for %0d cycles, expected low", waits);
      end
      @(posedge clk);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_err();
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   initial begin
      int w;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_waitrequest", 32'(waitrequest), 32'd1);
      check("rst_rdvalid", 32'(readdatavalid), 32'd0);
      check("rst_readdata", readdata, 32'h0);
      check("rst_regs_zero", 32'(reg_q[32*NUM_REGS-1:32] != '0), 32'd0);
      check("rst_reg0", word(0), REG0_RST);
      check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
      check("rst_err", 32'(err_addr), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Full write to reg 2
      avm_req(17'h0008, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b0, w);
      check("wr_waits", 32'(w), 32'd2);
      @(negedge clk);
      check("wr_strobe_full", 32'(wr_strobe), 32'h4);
      check("reg2_full", word(2), 32'h1234_5678);
      @(negedge clk);
      check("wr_strobe_single", 32'(wr_strobe), 32'h0);

      // Partial write, then read back
      avm_req(17'h0008, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, w);
      @(negedge clk);
      check("reg2_partial", word(2), 32'h12BB_56DD);
      avm_req(17'h0008, 1'b1, 1'b0, 32'h0, 4'h0, 32'h12BB_56DD, 1'b1, w);
      check("rd_waits", 32'(w), 32'd2);
      idle(4);
      check("err_clean", 32'(err_addr), 32'd0);

      // Out-of-range read
      avm_req(17'h0100, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, w);
      idle(4);
      check("err_oor_read", 32'(err_addr), 32'd1);
      clear_err();
      @(negedge clk);
      check("err_cleared", 32'(err_addr), 32'd0);

      // byteenable = 0: strobe only
      avm_req(17'h0008, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, w);
      @(negedge clk);
      check("be0_strobe", 32'(wr_strobe), 32'h4);
      check("be0_reg2", word(2), 32'h12BB_56DD);
      check("be0_err", 32'(err_addr), 32'd0);

      // Last register
      avm_req(17'h003C, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, w);
      @(negedge clk);
      check("last_strobe", 32'(wr_strobe), 32'h8000);
      check("reg15", word(15), 32'hDEAD_BEEF);
      avm_req(17'h003C, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, w);
      idle(4);

      // First out-of-range index
      avm_req(17'h0040, 1'b0, 1'b1, 32'h0000_0001, 4'hF, 32'h0, 1'b0, w);
      @(negedge clk);
      check("oor_wr_strobe", 32'(wr_strobe), 32'h0);
      check("oor_wr_err", 32'(err_addr), 32'd1);
      check("oor_wr_reg0", word(0), REG0_RST);
      clear_err();

      // Read and write together
      avm_req(17'h0004, 1'b1, 1'b1, 32'h0000_00FF, 4'hF, 32'h0, 1'b0, w);
      @(negedge clk);
      check("rw_reg1", word(1), 32'h0000_00FF);
      check("rw_strobe", 32'(wr_strobe), 32'h2);
      check("rw_err", 32'(err_addr), 32'd1);
      idle(4);
      clear_err();

`ifdef AVMM_CSR_RSP_ID_REG_EN
      avm_req(17'h0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, w);
      @(negedge clk);
      check("id_wr_strobe", 32'(wr_strobe), 32'h0);
      check("id_wr_err", 32'(err_addr), 32'd1);
      check("id_reg0", word(0), 32'hA1B0_0001);
      avm_req(17'h0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'hA1B0_0001, 1'b1, w);
      idle(4);
      clear_err();
`else
      avm_req(17'h0000, 1'b0, 1'b1, 32'h0000_0055, 4'hF, 32'h0, 1'b0, w);
      @(negedge clk);
      check("reg0_strobe", 32'(wr_strobe), 32'h1);
      check("reg0_data", word(0), 32'h0000_0055);
      check("reg0_err", 32'(err_addr), 32'd0);
      avm_req(17'h0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0000_0055, 1'b1, w);
      idle(4);
`endif

      // Reset while a read is in its latency window: no response may appear
      avm_req(17'h0008, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, w);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_waitrequest", 32'(waitrequest), 32'd1);
      idle(1);
      @(negedge clk);
      check("midrst_regs_zero", 32'(reg_q[32*NUM_REGS-1:32] != '0), 32'd0);
      check("midrst_reg0", word(0), REG0_RST);
      check("midrst_wr_strobe", 32'(wr_strobe), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_waitrequest", 32'(waitrequest), 32'd1);
      idle(5);

      check("rd_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/avalon_mm_csr_responder.md
Name: avalon_mm_csr_responder

Overview:
- Avalon-MM responder (slave) terminating the 17-bit address / 32-bit data CSR bus driven by DV and PHY configuration masters.
- Implements a bank of byte-enabled 32-bit registers with programmable wait states and fixed read latency.
- Exports register contents to downstream AIB PHY logic.
- Single outstanding transaction; no pipelined reads.

Parameters:
- NUM_REGS, 16: number of 32-bit registers (1..256).
- BASE_ADDR, 17'h0: byte address of register 0; must be 4-byte aligned.
- WAIT_STATES, 1: extra waitrequest-high cycles after request detection (0..15).
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid (1..8).
- ID_VALUE, 32'hA1B0_0001: read-only ID word, used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- address  in  17  byte address; bits [1:0] ignored.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write; ignored for read.
- readdata  out  32  read data, qualified by readdatavalid.
- readdatavalid  out  1  one-cycle read response pulse.
- waitrequest  out  1  high = request not accepted this cycle.
- reg_q  out  32*NUM_REGS  flattened register contents; reg i at bits [32*i+31:32*i].
- wr_strobe  out  NUM_REGS  one-cycle pulse per register written.
- err_addr  out  1  sticky out-of-range / protocol error flag.
- err_clr  in  1  clears err_addr.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - All registers, readdata, and wr_strobe = 0.
  - readdatavalid = 0, err_addr = 0.
  - waitrequest = 1 while rst is high. State = IDLE.
- FSM states IDLE, WAIT, ACCEPT, RDLAT. waitrequest is combinational from state: 0 only in ACCEPT, 1 otherwise.
- IDLE:
  - read or write sampled high -> WAIT, loading wait counter with WAIT_STATES.
  - If WAIT_STATES=0, go directly to ACCEPT.
- WAIT: counter decrements; at 0 -> ACCEPT. Minimum waitrequest-high time is 1+WAIT_STATES cycles.
- ACCEPT, request still high (transaction accepted):
  - Write: merge writedata into the target register per byteenable; wr_strobe[idx] pulses the next cycle; -> IDLE.
  - byteenable=0: accepted, register unchanged, wr_strobe still pulses.
  - Read: capture the target register into an internal holding register; -> RDLAT with counter READ_LATENCY-1.
- ACCEPT, request dropped: -> IDLE, no side effect.
- RDLAT:
  - readdata is updated and readdatavalid pulses high for exactly one cycle, READ_LATENCY cycles after the acceptance edge.
  - Then -> IDLE. readdata holds its value until the next read response.
- Address decode:
  - idx = (address - BASE_ADDR) >> 2.
  - Out of range (below BASE_ADDR or idx >= NUM_REGS): write dropped; read returns 32'h0 with normal timing; err_addr set.
- read and write both high at acceptance: write performed, read ignored, err_addr set.
- err_clr and a new error in the same cycle: set wins.
- Back-to-back: the cycle after the response/accept completes, state is IDLE, and a still-asserted request starts a new transaction. A request held high is executed repeatedly.
- rst mid-transaction: FSM returns to IDLE next edge, pending read is discarded (no readdatavalid), all registers are cleared.

Optional Feature:
- Macro AVMM_CSR_RSP_ID_REG_EN.
- Defined:
  - Register 0 is read-only and returns ID_VALUE.
  - Writes to index 0 are dropped, set err_addr, and produce no wr_strobe[0].
  - reg_q[31:0] = ID_VALUE.
- Undefined: register 0 is an ordinary R/W register and ID_VALUE is unused.

Decomposition:
- Package avalon_mm_csr_pkg holds:
  - widths AVMM_ADDR_W=17, AVMM_DATA_W=32, AVMM_BE_W=4;
  - state enum csr_rsp_state_e {IDLE, WAIT, ACCEPT, RDLAT};
  - the default ID constant.
- One sub-module is natural: avalon_mm_csr_be_merge, a combinational byte-enable merge of old data, new data, and byteenable.

Test Plan:
- Reset, then write addr 17'h0008, be 4'hF, data 32'h1234_5678 -> waitrequest low exactly 2 cycles after request (WAIT_STATES=1); wr_strobe[2] pulses once; reg_q word 2 = 32'h1234_5678.
- Partial write be 4'b0101, data 32'hAABB_CCDD to the same address -> reg 2 = 32'h12BB_56DD. Read addr 17'h0008 -> readdatavalid 2 cycles after the accept cycle, readdata = 32'h12BB_56DD.
- Read addr 17'h0100 (out of range, NUM_REGS=16) -> readdata = 32'h0, readdatavalid pulses, err_addr = 1. Pulse err_clr -> err_addr = 0.
- Assert read and write together at addr 17'h0004, data 32'h0000_00FF -> reg 1 = 32'h0000_00FF, no readdatavalid, err_addr = 1.
- Assert rst during RDLAT of a read -> no readdatavalid, all reg_q = 0, waitrequest high during reset and in IDLE.
- With AVMM_CSR_RSP_ID_REG_EN: write 32'hFFFF_FFFF to addr 0 -> no wr_strobe[0], err_addr = 1; read addr 0 returns 32'hA1B0_0001.
